// File: rtl/mul_wb_unit.sv
// Multi-cycle unsigned shift-add multiplier with write-back of the product into the
// register file (low half to dest, optional high half to dest+1) under a core grant.
module mul_wb_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADR_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  wide_i,
  input  logic [DATA_WIDTH-1:0] rs_val_i,
  input  logic [DATA_WIDTH-1:0] rd_val_i,
  input  logic [ADR_WIDTH-1:0]  dest_addr_i,
  input  logic                  wb_grant_i,
  output logic                  busy_o,
  output logic                  wb_req_o,
  output logic                  wen_o,
  output logic [ADR_WIDTH-1:0]  wa_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  done_o
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_WB_LO = 2'd2;
  localparam logic [1:0] S_WB_HI = 2'd3;

  logic [1:0]              state_r;
  logic [1:0]              state_nxt_s;
  logic [DATA_WIDTH-1:0]   mcand_r;
  logic [DATA_WIDTH-1:0]   mplier_r;
  logic [2*DATA_WIDTH-1:0] prod_r;
  logic [2*DATA_WIDTH-1:0] prod_nxt_s;
  logic [DATA_WIDTH:0]     sum_s;
  logic [CW-1:0]           cnt_r;
  logic [ADR_WIDTH-1:0]    dest_r;
  logic                    wide_r;
  logic                    busy_r;
  logic                    wb_req_r;
  logic                    done_r;
  logic [ADR_WIDTH-1:0]    wa_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic                    last_s;
  logic                    grant_s;

  // One shift-add step: the extra sum bit is the carry shifted into the product MSB.
  always_comb begin
    sum_s = {1'b0, prod_r[2*DATA_WIDTH-1:DATA_WIDTH]};
    if (mplier_r[0]) begin
      sum_s = {1'b0, prod_r[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, mcand_r};
    end else begin
      sum_s = {1'b0, prod_r[2*DATA_WIDTH-1:DATA_WIDTH]};
    end
    prod_nxt_s = {sum_s, prod_r[DATA_WIDTH-1:1]};
    last_s     = (cnt_r == CW'(DATA_WIDTH - 1));
    grant_s    = wb_req_r & wb_grant_i;
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_i) state_nxt_s = S_CALC;
        else         state_nxt_s = S_IDLE;
      end
      S_CALC: begin
        if (last_s) state_nxt_s = S_WB_LO;
        else        state_nxt_s = S_CALC;
      end
      S_WB_LO: begin
        if (grant_s) state_nxt_s = wide_r ? S_WB_HI : S_IDLE;
        else         state_nxt_s = S_WB_LO;
      end
      S_WB_HI: begin
        if (grant_s) state_nxt_s = S_IDLE;
        else         state_nxt_s = S_WB_HI;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, datapath and write-port registers; write address/data are loaded on entry to each WB state.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r  <= S_IDLE;
      mcand_r  <= {DATA_WIDTH{1'b0}};
      mplier_r <= {DATA_WIDTH{1'b0}};
      prod_r   <= {(2*DATA_WIDTH){1'b0}};
      cnt_r    <= {CW{1'b0}};
      dest_r   <= {ADR_WIDTH{1'b0}};
      wide_r   <= 1'b0;
      busy_r   <= 1'b0;
      wb_req_r <= 1'b0;
      done_r   <= 1'b0;
      wa_r     <= {ADR_WIDTH{1'b0}};
      wdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      busy_r   <= (state_nxt_s != S_IDLE);
      wb_req_r <= (state_nxt_s == S_WB_LO) || (state_nxt_s == S_WB_HI);
      done_r   <= grant_s && (state_nxt_s == S_IDLE);
      case (state_r)
        S_IDLE: begin
          if (start_i) begin
            mcand_r  <= rs_val_i;
            mplier_r <= rd_val_i;
            dest_r   <= dest_addr_i;
            wide_r   <= wide_i;
            prod_r   <= {(2*DATA_WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
          end else begin
            cnt_r    <= cnt_r;
          end
        end
        S_CALC: begin
          prod_r   <= prod_nxt_s;
          mplier_r <= {1'b0, mplier_r[DATA_WIDTH-1:1]};
          cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_s) begin
            wa_r    <= dest_r;
            wdata_r <= prod_nxt_s[DATA_WIDTH-1:0];
          end else begin
            wa_r    <= wa_r;
          end
        end
        S_WB_LO: begin
          if (grant_s && wide_r) begin
            wa_r    <= dest_r + {{(ADR_WIDTH-1){1'b0}}, 1'b1};
            wdata_r <= prod_r[2*DATA_WIDTH-1:DATA_WIDTH];
          end else begin
            wdata_r <= prod_r[DATA_WIDTH-1:0];
          end
        end
        default: begin
          wa_r <= wa_r;
        end
      endcase
    end
  end

  assign busy_o       = busy_r;
  assign wb_req_o     = wb_req_r;
  assign wen_o        = wb_req_r & wb_grant_i;
  assign wa_o         = wa_r;
  assign write_data_o = wdata_r;
  assign done_o       = done_r;

endmodule

// File: tb/tb_mul_wb_unit.sv
// Bench for mul_wb_unit: vector table, hand sequences for stall/reset corners and random ops,
// with a write scoreboard checked on every wen_o.
module tb_mul_wb_unit;

  logic        clk;
  logic        rst_n_i;
  logic        start_i;
  logic        wide_i;
  logic [15:0] rs_val_i;
  logic [15:0] rd_val_i;
  logic [4:0]  dest_addr_i;
  logic        wb_grant_i;
  logic        busy_o;
  logic        wb_req_o;
  logic        wen_o;
  logic [4:0]  wa_o;
  logic [15:0] write_data_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  wa;
    logic [15:0] d;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic [15:0] rs;
    logic [15:0] rd;
    logic [4:0]  dest;
    logic        wide;
    logic [15:0] lo;
    logic [15:0] hi;
  } vec_t;
  vec_t vecs[6];

  mul_wb_unit #(.DATA_WIDTH(16), .ADR_WIDTH(5)) dut (
    .clk          (clk),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .wide_i       (wide_i),
    .rs_val_i     (rs_val_i),
    .rd_val_i     (rd_val_i),
    .dest_addr_i  (dest_addr_i),
    .wb_grant_i   (wb_grant_i),
    .busy_o       (busy_o),
    .wb_req_o     (wb_req_o),
    .wen_o        (wen_o),
    .wa_o         (wa_o),
    .write_data_o (write_data_o),
    .done_o       (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (wen_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got wa=%0d data=%h required no write", wa_o, write_data_o);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (wa_o !== e.wa || write_data_o !== e.d) begin
          errors++;
          $display("FAIL wb_write got wa=%0d data=%h required wa=%0d data=%h",
                   wa_o, write_data_o, e.wa, e.d);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic push_op(input logic [4:0] dest, input logic wide,
                         input logic [15:0] lo, input logic [15:0] hi);
    logic [4:0] d1;
    d1 = dest + 5'd1;
    sb.push_back('{dest, lo});
    if (wide) sb.push_back('{d1, hi});
  endtask

  // Drive one operation to completion; imm starts it in the current (done) cycle.
  task automatic run_op(input logic [15:0] rs, input logic [15:0] rd, input logic [4:0] dest,
                        input logic wide, input logic [15:0] lo, input logic [15:0] hi,
                        input bit stall, input bit imm);
    int n;
    if (!imm) cycle();
    start_i = 1'b1; rs_val_i = rs; rd_val_i = rd; dest_addr_i = dest; wide_i = wide;
    wb_grant_i = 1'b1;
    push_op(dest, wide, lo, hi);
    cycle();
    start_i = 1'b0;
    rs_val_i = 16'($urandom); rd_val_i = 16'($urandom);
    dest_addr_i = 5'($urandom); wide_i = 1'($urandom);
    n = 0;
    while (!done_o && n < 200) begin
      wb_grant_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      n++;
    end
    if (n >= 200) begin
      errors++; checks++;
      $display("FAIL op_timeout got %0d cycles required done_o", n);
    end else if (!stall) begin
      check("op_latency", 64'(n), wide ? 64'd18 : 64'd17);
    end
    check("sb_drained", 64'(sb.size()), 64'd0);
    wb_grant_i = 1'b1;
  endtask

  initial begin
    logic [31:0] p;
    int n;
    bit stall;
    vecs[0] = '{16'h0003, 16'h0005, 5'd4,  1'b0, 16'h000F, 16'h0000};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 5'd10, 1'b1, 16'h0001, 16'hFFFE};
    vecs[2] = '{16'h1234, 16'h0100, 5'd31, 1'b1, 16'h3400, 16'h0012};
    vecs[3] = '{16'h0000, 16'h1234, 5'd5,  1'b1, 16'h0000, 16'h0000};
    vecs[4] = '{16'h8000, 16'h0002, 5'd0,  1'b1, 16'h0000, 16'h0001};
    vecs[5] = '{16'h0007, 16'h0006, 5'd0,  1'b0, 16'h002A, 16'h0000};

    rst_n_i = 1'b0; start_i = 1'b0; wide_i = 1'b0; rs_val_i = 16'h0; rd_val_i = 16'h0;
    dest_addr_i = 5'd0; wb_grant_i = 1'b0;
    repeat (2) cycle();
    check("reset_outputs", {40'd0, busy_o, wb_req_o, wen_o, done_o, wa_o, write_data_o}, 64'd0);
    rst_n_i = 1'b1;

    // Basic op with latency, then done pulse drops and busy stays low.
    run_op(16'h0003, 16'h0005, 5'd4, 1'b0, 16'h000F, 16'h0000, 1'b0, 1'b0);
    check("done_busy_in_done_cycle", {62'd0, done_o, busy_o}, 64'd2);
    cycle();
    check("done_pulse_one_cycle", {62'd0, done_o, busy_o}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].rs, vecs[i].rd, vecs[i].dest, vecs[i].wide, vecs[i].lo, vecs[i].hi,
             1'b0, (i == 3));
    end

    // Grant withheld in WB_LO: request held, outputs stable, new starts ignored.
    cycle();
    start_i = 1'b1; rs_val_i = 16'h00AB; rd_val_i = 16'h0010; dest_addr_i = 5'd7; wide_i = 1'b0;
    wb_grant_i = 1'b0;
    push_op(5'd7, 1'b0, 16'h0AB0, 16'h0000);
    cycle();
    start_i = 1'b0;
    n = 0;
    while (!wb_req_o && n < 40) begin cycle(); n++; end
    check("stall_reach_wb", 64'(n < 40), 64'd1);
    for (int k = 0; k < 5; k++) begin
      check("stall_hold", {40'd0, wb_req_o, wen_o, busy_o, wa_o, write_data_o},
            {40'd0, 1'b1, 1'b0, 1'b1, 5'd7, 16'h0AB0});
      start_i = ~start_i; rs_val_i = 16'($urandom); rd_val_i = 16'($urandom);
      dest_addr_i = 5'($urandom);
      cycle();
    end
    start_i = 1'b0;
    wb_grant_i = 1'b1;
    n = 0;
    while (!done_o && n < 10) begin cycle(); n++; end
    check("stall_done", 64'(done_o), 64'd1);
    check("stall_sb_drained", 64'(sb.size()), 64'd0);
    repeat (25) cycle();
    check("stall_no_restart", {62'd0, busy_o, wb_req_o}, 64'd0);

    // Reset during CALC cycle 8 aborts with no write; next op completes.
    cycle();
    start_i = 1'b1; rs_val_i = 16'h1111; rd_val_i = 16'h2222; dest_addr_i = 5'd9; wide_i = 1'b1;
    cycle();
    start_i = 1'b0;
    repeat (7) cycle();
    check("busy_before_abort", 64'(busy_o), 64'd1);
    rst_n_i = 1'b0;
    #1;
    check("abort_outputs", {40'd0, busy_o, wb_req_o, wen_o, done_o, wa_o, write_data_o}, 64'd0);
    repeat (2) cycle();
    rst_n_i = 1'b1;
    repeat (20) cycle();
    check("abort_idle", {62'd0, busy_o, wb_req_o}, 64'd0);
    run_op(16'h0007, 16'h0006, 5'd3, 1'b0, 16'h002A, 16'h0000, 1'b0, 1'b0);

    // Random ops against the arithmetic model with random grant stalls.
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom); b = 16'($urandom);
      if (i % 10 == 0) a = 16'h0000;
      stall = ($urandom_range(0, 3) == 0);
      p = {16'h0000, a} * {16'h0000, b};
      run_op(a, b, 5'($urandom), 1'($urandom), p[15:0], p[31:16], stall, 1'b0);
      if (errors > 20) break;
    end

    repeat (5) cycle();
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
